// File: rtl/dmem_access_unit_if.sv
// Core-side and bus-side signals of the data-memory access unit.
// The unit is the bus master; the core/memory model side uses the slave view.
interface dmem_access_unit_if;
    logic        cpu_req;
    logic        ram_we;
    logic [1:0]  ram_wdin_op;
    logic [2:0]  ram_rb_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        input  cpu_req, ram_we, ram_wdin_op, ram_rb_op, addr, wdata, bus_ack, bus_rdata,
        output stall, done, err, rdata, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
    );

    modport slave (
        output cpu_req, ram_we, ram_wdin_op, ram_rb_op, addr, wdata, bus_ack, bus_rdata,
        input  stall, done, err, rdata, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Multi-cycle load/store unit: one req/ack bus transaction per access, with
// byte strobes, lane replication, load extension, misalignment and timeout.
module dmem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    dmem_access_unit_if.master dif
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             we_q, err_q;
    logic [1:0]       wop_q;
    logic [2:0]       rop_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic             is_half, is_word, misaligned, timeout_hit, busy;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_ext, wdata_rep;
    logic [3:0]       wstrb;

    // Alignment is judged on the live request since fields are latched on leaving IDLE.
    always_comb begin
        is_half = 1'b0;
        is_word = 1'b0;
        if (dif.ram_we) begin
            is_half = (dif.ram_wdin_op == 2'd1);
            is_word = dif.ram_wdin_op[1];
        end else begin
            is_half = (dif.ram_rb_op == 3'd2) || (dif.ram_rb_op == 3'd3);
            is_word = dif.ram_rb_op[2];
        end
        misaligned = (is_half && dif.addr[0]) || (is_word && (dif.addr[1:0] != 2'b00));
    end

    assign timeout_hit = (cnt == CNT_LAST);
    assign busy        = (state == BUSY);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dif.cpu_req) state_nxt = misaligned ? DONE : BUSY;
            BUSY:    if (dif.bus_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: ld_byte = dif.bus_rdata[7:0];
            2'd1: ld_byte = dif.bus_rdata[15:8];
            2'd2: ld_byte = dif.bus_rdata[23:16];
            2'd3: ld_byte = dif.bus_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = addr_q[1] ? dif.bus_rdata[31:16] : dif.bus_rdata[15:0];
        case (rop_q)
            3'd0:    load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    load_ext = {24'h000000, ld_byte};
            3'd2:    load_ext = {{16{ld_half[15]}}, ld_half};
            3'd3:    load_ext = {16'h0000, ld_half};
            default: load_ext = dif.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            wop_q   <= 2'd0;
            rop_q   <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (dif.cpu_req) begin
                    cnt     <= '0;
                    we_q    <= dif.ram_we;
                    wop_q   <= dif.ram_wdin_op;
                    rop_q   <= dif.ram_rb_op;
                    addr_q  <= dif.addr;
                    wdata_q <= dif.wdata;
                    rdata_q <= 32'h0;
                    err_q   <= misaligned;
                end
                BUSY: begin
                    // Ack takes priority over a coincident timeout.
                    if (dif.bus_ack) begin
                        rdata_q <= load_ext;
                        err_q   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timeout_hit) begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (wop_q)
            2'd0: begin
                wstrb     = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                wstrb     = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
        if (!we_q) wstrb = 4'b0000;
    end

    assign dif.stall     = ((state == IDLE) && dif.cpu_req) || busy;
    assign dif.done      = (state == DONE);
    assign dif.err       = (state == DONE) && err_q;
    assign dif.rdata     = (state == DONE) ? rdata_q : 32'h0;
    assign dif.bus_req   = busy;
    assign dif.bus_we    = busy && we_q;
    assign dif.bus_addr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dif.bus_wstrb = busy ? wstrb : 4'b0000;
    assign dif.bus_wdata = busy ? wdata_rep : 32'h0;
endmodule
